// File: rtl/gpr_pkg.sv
// Shared constants and types for the general-purpose register file and its
// issue scoreboard.
package gpr_pkg;

  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_DATA_WIDTH = 32;
  localparam int GPR_NUM_RD     = 2;

  typedef logic [GPR_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy tracking for in-flight destinations, RAW/WAW issue
// interlock, live busy count and a sticky unexpected-writeback flag.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int NUM_RD     = GPR_NUM_RD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_rd,
  output logic                         issue_ready,
  output logic [ADDR_WIDTH:0]          busy_cnt,
  output logic                         wb_err
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [NREG-1:0] busy;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] busy_eff;
  logic            hazard;
  logic            wb_live;
  logic            do_set;
  logic            do_clr;

  // A writeback landing this cycle already releases its register, so a
  // dependent instruction may issue alongside it and take the bypassed value.
  always_comb begin
    wb_mask = '0;
    if (wen) wb_mask[waddr] = 1'b1;
    busy_eff = busy & ~wb_mask;
    hazard   = busy_eff[issue_rd];
    for (int k = 0; k < NUM_RD; k++) begin
      hazard = hazard | busy_eff[raddr[k*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  assign issue_ready = ~hazard;
  assign wb_live     = wen && (waddr != '0);
  assign do_set      = issue_valid && issue_ready && (issue_rd != '0);
  assign do_clr      = wb_live && busy[waddr];

  // Set is applied after clear so a same-register collision leaves it busy;
  // the count follows real bit transitions so it always equals popcount(busy).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      if (wb_live) busy[waddr] <= 1'b0;
      if (do_set) busy[issue_rd] <= 1'b1;
      if (do_set && !do_clr) busy_cnt <= busy_cnt + CNT_ONE;
      else if (!do_set && do_clr) busy_cnt <= busy_cnt - CNT_ONE;
      if (wb_live && !busy[waddr]) wb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/gpr_sb.sv
// Register file with hard-wired zero register, combinational multi-port reads,
// optional write-to-read forwarding and an issue scoreboard.
module gpr_sb
  import gpr_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int NUM_RD     = GPR_NUM_RD,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_rd,
  output logic                         issue_ready,
  output logic [ADDR_WIDTH:0]          busy_cnt,
  output logic                         wb_err,
  input  logic [ADDR_WIDTH-1:0]        dbg_raddr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else if (wen && (waddr != '0)) begin
      rf[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (raddr[k*ADDR_WIDTH +: ADDR_WIDTH] == '0)
        rdata[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if ((BYPASS != 0) && wen && (waddr == raddr[k*ADDR_WIDTH +: ADDR_WIDTH]))
        rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata;
      else
        rdata[k*DATA_WIDTH +: DATA_WIDTH] = rf[raddr[k*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  // rf[0] is never written, so the debug port needs no zero special case.
  assign dbg_rdata = rf[dbg_raddr];

  // Issue handshake: an instruction is accepted on a rising edge where
  // issue_valid and issue_ready are both 1; issue_ready depends only on the
  // current sources, destination and writeback, never on issue_valid, and a
  // refused request (valid=1, ready=0) leaves the scoreboard untouched.
  gpr_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_RD    (NUM_RD)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .raddr      (raddr),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .busy_cnt   (busy_cnt),
    .wb_err     (wb_err)
  );

endmodule

// File: doc/gpr_sb.md
GPR_SB -- requirements
Module: gpr_sb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, register index width (2**ADDR_WIDTH registers).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 The block SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding.
REQ-005 clk  in  1  the only clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 wen  in  1  writeback valid.
REQ-008 waddr  in  ADDR_WIDTH  writeback index.
REQ-009 wdata  in  DATA_WIDTH  writeback data.
REQ-010 raddr  in  NUM_RD*ADDR_WIDTH  packed read indices; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 rdata  out  NUM_RD*DATA_WIDTH  packed read data, same packing.
REQ-012 issue_valid  in  1  an instruction requests issue, with sources on raddr and destination on issue_rd.
REQ-013 issue_rd  in  ADDR_WIDTH  destination index of the issuing instruction.
REQ-014 issue_ready  out  1  issue is permitted this cycle.
REQ-015 busy_cnt  out  ADDR_WIDTH+1  number of registers currently marked busy.
REQ-016 wb_err  out  1  sticky flag: a writeback targeted a non-busy register.
REQ-017 dbg_raddr  in  ADDR_WIDTH  debug read index.
REQ-018 dbg_rdata  out  DATA_WIDTH  debug read data; never bypassed.

Function
REQ-019 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never be marked busy.
REQ-020 Reads SHALL be combinational (zero latency).
REQ-021 With BYPASS=1, when wen=1 and waddr=raddr[k]!=0, rdata[k] SHALL equal wdata in the same cycle; with BYPASS=0 it SHALL return the old value.
REQ-022 When wen=1 and waddr!=0, rf[waddr] SHALL take wdata at the next clk edge.
REQ-023 Each register r SHALL have a busy bit; busy_eff[r] = busy[r] AND NOT (wen AND waddr==r).
REQ-024 issue_ready SHALL be 1 only if busy_eff is 0 for every raddr[k] (RAW hazard) and for issue_rd (WAW hazard); it SHALL be combinational.
REQ-025 On an edge where issue_valid AND issue_ready AND issue_rd!=0 hold, busy[issue_rd] SHALL be set.
REQ-026 On an edge where wen=1 and waddr!=0, busy[waddr] SHALL be cleared.
REQ-027 If a set and a clear target the same register on the same edge, the set SHALL win.
REQ-028 If wen=1, waddr!=0 and busy[waddr]=0, the write SHALL still occur and wb_err SHALL become 1, remaining 1 until reset.
REQ-029 busy_cnt SHALL track the popcount of busy, updated incrementally: +1 on set, -1 on clear, and unchanged when both occur on the same edge (for the same or different registers).
REQ-030 When issue_valid=1 and issue_ready=0, the block SHALL change no state except through writeback.

Reset
REQ-031 While rst=0, all registers SHALL be 0, all busy bits 0, busy_cnt 0 and wb_err 0, asynchronously.
REQ-032 Reset asserted mid-operation SHALL discard all pending busy marks; the first edge after rst rises SHALL behave as a normal cycle.

Structure
REQ-033 Package gpr_pkg SHALL hold the default ADDR_WIDTH, DATA_WIDTH and NUM_RD constants and the register-index typedef.
REQ-034 The busy bits, busy_cnt and wb_err SHALL live in sub-module gpr_scoreboard; the storage and bypass SHALL stay in gpr_sb.

Verification
REQ-035 Reset, then write x5=0xDEADBEEF with raddr0=5 in the same cycle -> rdata0=0xDEADBEEF combinationally (BYPASS=1); with BYPASS=0 -> rdata0=0 that cycle and 0xDEADBEEF the next.
REQ-036 Write x0=0x1234 -> rdata reads 0 and busy_cnt stays 0.
REQ-037 Issue rd=3 -> busy_cnt=1; next cycle issue with raddr1=3 -> issue_ready=0; wen waddr=3 in the same cycle -> issue_ready=1 and the value is bypassed.
REQ-038 Issue rd=7 while wen waddr=7 clears it on the same edge -> busy[7]=1 and busy_cnt unchanged.
REQ-039 wen waddr=9 with x9 not busy -> x9 written and wb_err=1, remaining 1 after further traffic.
REQ-040 Issue rd=2 and rd=4, then pulse rst low -> busy_cnt=0, issue_ready=1 and all registers read 0.
